// File: rtl/fp_pkg.sv
// Shared definitions for the iterative floating-point units: operand classes,
// flag bit positions and the width-derivation helpers.
package fp_pkg;
  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_cls_e;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_OVERFLOW  = 3;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_INEXACT   = 1;
  localparam int FLAG_ZERO      = 0;

  function automatic int calc_nchunk(input int sig_w, input int part_w);
    return (sig_w + part_w - 1) / part_w;
  endfunction

  function automatic int calc_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/fp_round_rne.sv
// Normalise a raw significand product, round to nearest-even and pack the
// result with exception handling. Purely combinational.
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [2*(MAN_W+1)-1:0] acc_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic                    sign_i,
  input  fp_cls_e                 cls_a_i,
  input  fp_cls_e                 cls_b_i,
  output logic [EXP_W+MAN_W:0]    result_o,
  output logic [4:0]              flags_o
);
  localparam int SIG_W = MAN_W + 1;
  localparam int EW2   = EXP_W + 2;
  localparam logic signed [EW2-1:0] ONE  = EW2'(1);
  localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] ZERO = '0;

  logic [SIG_W-1:0]     sig;
  logic [SIG_W:0]       rnd;
  logic                 guard, sticky, inexact;
  logic signed [EW2-1:0] exp_n, exp_r;
  logic [MAN_W-1:0]     man;

  always_comb begin
    if (acc_i[2*SIG_W-1]) begin
      sig    = acc_i[2*SIG_W-1 -: SIG_W];
      guard  = acc_i[SIG_W-1];
      sticky = |acc_i[SIG_W-2:0];
      exp_n  = exp_i + ONE;
    end else begin
      sig    = acc_i[2*SIG_W-2 -: SIG_W];
      guard  = acc_i[SIG_W-2];
      sticky = |acc_i[SIG_W-3:0];
      exp_n  = exp_i;
    end
    inexact = guard | sticky;
    rnd = {1'b0, sig} + {{SIG_W{1'b0}}, guard & (sticky | sig[0])};
    // Carry out of the significand: 1.111.. rounded up to 10.000..
    if (rnd[SIG_W]) begin
      man   = '0;
      exp_r = exp_n + ONE;
    end else begin
      man   = rnd[MAN_W-1:0];
      exp_r = exp_n;
    end

    flags_o = '0;
    if (cls_a_i == FP_NAN || cls_b_i == FP_NAN ||
        (cls_a_i == FP_INF && cls_b_i == FP_ZERO) ||
        (cls_a_i == FP_ZERO && cls_b_i == FP_INF)) begin
      result_o = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_o[FLAG_INVALID] = 1'b1;
    end else if (cls_a_i == FP_INF || cls_b_i == FP_INF) begin
      result_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls_a_i == FP_ZERO || cls_b_i == FP_ZERO) begin
      result_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_o[FLAG_ZERO] = 1'b1;
    end else if (exp_r >= EMAX) begin
      result_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_o[FLAG_OVERFLOW] = 1'b1;
      flags_o[FLAG_INEXACT]  = 1'b1;
    end else if (exp_r <= ZERO) begin
      result_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_o[FLAG_UNDERFLOW] = 1'b1;
      flags_o[FLAG_INEXACT]   = 1'b1;
      flags_o[FLAG_ZERO]      = 1'b1;
    end else begin
      result_o = {sign_i, exp_r[EXP_W-1:0], man};
      flags_o[FLAG_INEXACT] = inexact;
    end
  end
endmodule

// File: rtl/fp_iter_mul.sv
// Iterative floating-point multiplier: the significand product is accumulated
// over NCHUNK passes through one PART_W-wide multiplier slice.
module fp_iter_mul
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int PART_W = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [4:0]           flags
);
  localparam int SIG_W  = MAN_W + 1;
  localparam int NCHUNK = calc_nchunk(SIG_W, PART_W);
  localparam int BIAS   = calc_bias(EXP_W);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PAD_W  = NCHUNK * PART_W;
  localparam int ACC_W  = 2 * SIG_W;
  localparam int PROD_W = SIG_W + PART_W;
  localparam int WIDE_W = ACC_W + PAD_W;
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d;
  logic [SIG_W-1:0]        sig_a_q, sig_a_d;
  logic [PAD_W-1:0]        sig_b_q, sig_b_d;
  logic signed [EXP_W+1:0] exp_q, exp_d;
  logic                    sign_q, sign_d;
  fp_cls_e                 cls_a_q, cls_a_d, cls_b_q, cls_b_d;
  logic [CNT_W-1:0]        k_q, k_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [W-1:0]            result_q, result_d, rnd_res;
  logic [4:0]              flags_q, flags_d, rnd_flg;
  logic                    ready_q, ready_d;
  logic [PART_W-1:0]       chunk;
  logic [PROD_W-1:0]       partial;
  logic [WIDE_W-1:0]       shifted;

  function automatic fp_cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0)    return FP_ZERO;
    else if (&e)    return (m != '0) ? FP_NAN : FP_INF;
    else            return FP_NORM;
  endfunction

  // One slice multiply per cycle; the chunk weight is applied by the shift.
  assign chunk   = sig_b_q[k_q*PART_W +: PART_W];
  assign partial = {{PART_W{1'b0}}, sig_a_q} * {{SIG_W{1'b0}}, chunk};
  assign shifted = WIDE_W'(partial) << (k_q * PART_W);

  fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .acc_i   (acc_q),
    .exp_i   (exp_q),
    .sign_i  (sign_q),
    .cls_a_i (cls_a_q),
    .cls_b_i (cls_b_q),
    .result_o(rnd_res),
    .flags_o (rnd_flg)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sig_a_d  = sig_a_q;
    sig_b_d  = sig_b_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    cls_a_d  = cls_a_q;
    cls_b_d  = cls_b_q;
    k_d      = k_q;
    acc_d    = acc_q;
    result_d = result_q;
    flags_d  = flags_q;
    ready_d  = 1'b0;
    case (state_q)
      S_IDLE: if (run) begin
        a_d     = a;
        b_d     = b;
        state_d = S_UNPACK;
      end
      S_UNPACK: begin
        sig_a_d = (a_q[W-2 -: EXP_W] == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
        sig_b_d = (b_q[W-2 -: EXP_W] == '0) ? '0 : PAD_W'({1'b1, b_q[MAN_W-1:0]});
        exp_d   = $signed({2'b00, a_q[W-2 -: EXP_W]}) + $signed({2'b00, b_q[W-2 -: EXP_W]}) - BIAS_S;
        sign_d  = a_q[W-1] ^ b_q[W-1];
        cls_a_d = classify(a_q[W-2 -: EXP_W], a_q[MAN_W-1:0]);
        cls_b_d = classify(b_q[W-2 -: EXP_W], b_q[MAN_W-1:0]);
        acc_d   = '0;
        k_d     = '0;
        state_d = S_MUL;
      end
      S_MUL: begin
        acc_d = acc_q + shifted[ACC_W-1:0];
        if (k_q == CNT_W'(NCHUNK - 1)) state_d = S_ROUND;
        else                           k_d = k_q + 1'b1;
      end
      S_ROUND: state_d = S_DONE;
      S_DONE: begin
        result_d = rnd_res;
        flags_d  = rnd_flg;
        ready_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sig_a_q  <= '0;
      sig_b_q  <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      cls_a_q  <= FP_ZERO;
      cls_b_q  <= FP_ZERO;
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sig_a_q  <= sig_a_d;
      sig_b_q  <= sig_b_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      cls_a_q  <= cls_a_d;
      cls_b_q  <= cls_b_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      ready_q  <= ready_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign ready  = ready_q;
  assign result = result_q;
  assign flags  = flags_q;
endmodule

// File: doc/fp_iter_mul.md
Name: fp_iter_mul

Overview:
Parametrised iterative IEEE-754-style floating-point multiplier for the iterative DSP48E1 FP datapath. The successor to the fixed-width single-precision iterative unit.
- Exponent and mantissa widths are generics.
- The significand product is built over several passes through one narrow multiplier slice of PART_W bits, modelling the DSP B-port width.
- Adds RNE rounding, flush-to-zero and a 5-bit exception flag word, with a run/ready handshake.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored mantissa field width (>=2)
PART_W, 17, unsigned multiplier chunk width per pass (DSP B-port)
Derived, not overridable: SIG_W = MAN_W+1; NCHUNK = ceil(SIG_W/PART_W); BIAS = 2^(EXP_W-1)-1; W = 1+EXP_W+MAN_W

Ports:
clk  in  1  system clock
rst  in  1  reset
run  in  1  start request; sampled only when busy=0
a  in  W  operand A {sign, exp, man}
b  in  W  operand B
busy  out  1  operation in flight
ready  out  1  one-cycle pulse: result/flags valid
result  out  W  product; held until next ready
flags  out  5  {invalid, overflow, underflow, inexact, zero}; held with result

Interface constraint: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at posedge):
  - FSM to IDLE.
  - busy=0, ready=0, result=0, flags=0.
  - Accumulator and operand registers cleared.
  - Takes priority over everything. A reset mid-operation discards the operation and no ready is produced.
- FSM states: IDLE -> UNPACK -> MUL (NCHUNK cycles, chunk counter 0..NCHUNK-1) -> ROUND -> DONE -> IDLE.
- Latency is fixed. ready is asserted exactly NCHUNK+3 cycles after the run-accept edge: 5 for defaults, 4 when NCHUNK=1. Special operands take the same latency.
- IDLE:
  - run=1 latches a and b, sets busy=1 and goes to UNPACK.
  - run while busy=1 is ignored and not queued.
- UNPACK:
  - exp==0 is treated as zero (denormal inputs flushed). Hidden bit prepended.
  - Exponent sum computed as ea+eb-BIAS in a signed EXP_W+2 register.
  - Result sign = sa^sb.
  - Special class decided: NaN, inf, zero, normal.
- MUL:
  - Pass k computes sig_a x chunk_k(sig_b), where chunk_k = bits [k*PART_W +: PART_W] of sig_b, zero-extended at the top.
  - Product is added to the 2*SIG_W-bit accumulator, left-shifted by k*PART_W.
  - Exactly one multiply per cycle.
- ROUND:
  - If the product MSB (bit 2*SIG_W-1) is set: take the upper SIG_W bits and exponent+1. Otherwise shift by one.
  - Guard = next bit; sticky = OR of all lower bits.
  - Round to nearest, ties to even. A rounding carry out of the significand gives significand 1.0 and exponent+1.
  - inexact = guard|sticky.
- Exceptions, in priority order:
  1. Either input NaN, or inf x 0: result = canonical qNaN (sign 0, exp all ones, man MSB 1, rest 0); invalid=1.
  2. inf x finite nonzero: signed inf, no flags.
  3. Any zero input: signed zero, zero=1.
  4. Final exponent >= 2^EXP_W-1: signed inf; overflow=1, inexact=1.
  5. Final exponent <= 0: signed zero (flush); underflow=1, inexact=1, zero=1.
- DONE:
  - result and flags registered.
  - ready=1 for one cycle; busy falls in the same cycle.
  - A run in the DONE cycle is ignored. A new run is accepted in IDLE on the next cycle, so minimum issue interval is NCHUNK+4 cycles.

Decomposition:
- Shared package fp_pkg: FP class enum (FP_ZERO, FP_NORM, FP_INF, FP_NAN), flag bit index constants (FLAG_INVALID=4 .. FLAG_ZERO=0), and functions for width derivation (NCHUNK, BIAS).
- One sub-module, fp_round_rne: combinational normalise, round and exception-pack from the accumulator, exponent, sign and class to result and flags. It is reusable by the later adder unit.
- The FSM and accumulator stay in fp_iter_mul.

Test Plan:
1. 0x3FC00000 x 0x40000000, run pulse -> result 0x40400000, flags 0, ready exactly 5 cycles after run edge, busy high for cycles 1-4.
2. 0x3F800001 x 0x3F800001 -> 0x3F800002, flags=00010 (inexact). Also 0x3FFFFFFF x 0x3FFFFFFF -> 0x407FFFFE, inexact (checks normalise shift and rounding).
3. 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1. 0xFF800000 x 0x40000000 -> 0xFF800000, flags 0. 0x80000000 x 0x3F800000 -> 0x80000000, zero=1.
4. 0x7F7FFFFF x 0x40000000 -> 0x7F800000, overflow+inexact. 0x80800000 x 0x3F000000 -> 0x80000000, underflow+inexact+zero.
5. Handshake and reset:
   - run held high continuously -> ops issue every 6 cycles.
   - run pulse during MUL ignored.
   - rst asserted during MUL -> next cycle busy=0, no ready, result=0.
6. Parameter sweep EXP_W=5, MAN_W=10 (NCHUNK=1): 0x3C00 x 0x4000 -> 0x4000, ready 4 cycles after run. Random cross-check against a reference model across PART_W in {8, 17, 24}.
